// File: rtl/serial_borrow_subtractor.sv
// rtl/serial_borrow_subtractor.sv - multi-cycle ripple-borrow subtractor, DIGIT bits per clock
module serial_borrow_subtractor #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    // A single-slice configuration still needs a one-bit counter to exist.
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             last;
    logic [DIGIT-1:0] d;
    logic             brw_n;
    logic [WIDTH-1:0] diff_nxt;

    assign last = (cnt == CW'(N - 1));

    // State register; an asynchronous reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: accept only from IDLE, hand off only from DONE (never both in one cycle).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = BUSY;
            BUSY:    if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // One slice of the borrow chain and the diff word with that slice merged in.
    always_comb begin
        {brw_n, d} = {1'b0, a_r[cnt*DIGIT +: DIGIT]}
                   - {1'b0, b_r[cnt*DIGIT +: DIGIT]}
                   - {{DIGIT{1'b0}}, borrow};
        diff_nxt = diff;
        diff_nxt[cnt*DIGIT +: DIGIT] = d;
    end

    // Datapath: capture operands on accept, ripple one slice per BUSY cycle, flag on the last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= '0;
            b_r    <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r    <= a;
                        b_r    <= b;
                        borrow <= bin;
                        cnt    <= '0;
                    end
                end
                BUSY: begin
                    diff   <= diff_nxt;
                    borrow <= brw_n;
                    if (last) begin
                        cnt  <= '0;
                        bout <= brw_n;
                        // bin only feeds the borrow chain; overflow looks at operand and result signs.
                        ovf  <= (a_r[WIDTH-1] != b_r[WIDTH-1]) &&
                                (diff_nxt[WIDTH-1] != a_r[WIDTH-1]);
                        zero <= (diff_nxt == '0);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
